// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone Classic arbiter in front of a single SDRAM controller slave.
// Define SDRAM_ARB_ROUND_ROBIN_EN to alternate grants under contention (default: port 0 wins).
module sdram_wb_arbiter #(
    parameter int unsigned WB_ADDR_WIDTH  = 24,
    parameter int unsigned WB_DATA_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,

    input  logic                       m0_cyc_i,
    input  logic                       m0_stb_i,
    input  logic                       m0_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [WB_DATA_WIDTH/8-1:0] m0_sel_i,
    output logic [WB_DATA_WIDTH-1:0]   m0_dat_o,
    output logic                       m0_ack_o,
    output logic                       m0_err_o,

    input  logic                       m1_cyc_i,
    input  logic                       m1_stb_i,
    input  logic                       m1_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [WB_DATA_WIDTH/8-1:0] m1_sel_i,
    output logic [WB_DATA_WIDTH-1:0]   m1_dat_o,
    output logic                       m1_ack_o,
    output logic                       m1_err_o,

    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [WB_ADDR_WIDTH-1:0]   s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]   s_dat_o,
    output logic [WB_DATA_WIDTH/8-1:0] s_sel_o,
    input  logic [WB_DATA_WIDTH-1:0]   s_dat_i,
    input  logic                       s_ack_i,

    output logic [1:0]                 grant_o
);
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic [CntWidth-1:0] tcnt_q, tcnt_d;
    logic [CntWidth-1:0] tcnt_inc;

    logic req0, req1, winner;
    logic own_cyc;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign req0     = m0_cyc_i & m0_stb_i;
    assign req1     = m1_cyc_i & m1_stb_i;
    assign own_cyc  = owner_q ? m1_cyc_i : m0_cyc_i;
    assign tcnt_inc = (tcnt_q == CntMax) ? tcnt_q : tcnt_q + CntWidth'(1);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    assign winner = (req0 & req1) ? ~last_owner_q : req1;
`else
    assign winner = ~req0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        tcnt_d       = tcnt_q;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_adr_o      = '0;
        s_dat_o      = '0;
        s_sel_o      = '0;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        m0_err_o     = 1'b0;
        m1_err_o     = 1'b0;
        grant_o      = 2'b00;

        unique case (state_q)
            StIdle: begin
                // s_ack_i is ignored here; a stray ack must not start or end anything
                if (req0 | req1) begin
                    owner_d = winner;
                    tcnt_d  = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                s_cyc_o = own_cyc;
                s_stb_o = owner_q ? m1_stb_i : m0_stb_i;
                s_we_o  = owner_q ? m1_we_i  : m0_we_i;
                s_adr_o = owner_q ? m1_adr_i : m0_adr_i;
                s_dat_o = owner_q ? m1_dat_i : m0_dat_i;
                s_sel_o = owner_q ? m1_sel_i : m0_sel_i;
                grant_o = owner_q ? 2'b10 : 2'b01;
                if (owner_q) m1_ack_o = s_ack_i;
                else         m0_ack_o = s_ack_i;

                if (s_ack_i) begin
                    state_d      = StIdle;
                    last_owner_d = owner_q;
                end else if (!own_cyc) begin
                    // master gave up; wait out a possible late ack from the controller
                    state_d = StDrain;
                    tcnt_d  = '0;
                end else if (tcnt_q == CntMax) begin
                    if (owner_q) m1_err_o = 1'b1;
                    else         m0_err_o = 1'b1;
                    state_d = StDrain;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            StDrain: begin
                if (s_ack_i || tcnt_q == CntMax) state_d = StIdle;
                else                             tcnt_d  = tcnt_inc;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            tcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            tcnt_q       <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Self-checking bench for sdram_wb_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model of the arbitration rules.
module tb_sdram_wb_arbiter;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [23:0] m0_adr = 24'h000200;
    logic [15:0] m0_dat = 16'h1234;
    logic [1:0]  m0_sel = 2'b01;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [23:0] m1_adr = 24'h000100;
    logic [15:0] m1_dat = 16'hFFFF;
    logic [1:0]  m1_sel = 2'b11;
    logic [15:0] s_dat = 16'h0;
    logic        s_ack = 1'b0;

    logic [15:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [23:0] s_adr;
    logic [1:0]  s_sel, grant;

    int total = 0;
    int bad   = 0;

    // reference model: mode 0 idle, 1 serving, 2 draining
    int md, own, lst, cnt;

    // outputs captured at the last sampling point
    logic        cap_cyc, cap_stb, cap_we, cap_ack0, cap_ack1, cap_err0, cap_err1;
    logic [1:0]  cap_grant, cap_sel;
    logic [15:0] cap_sdat, cap_mdat0, cap_mdat1;

    sdram_wb_arbiter #(
        .WB_ADDR_WIDTH (24),
        .WB_DATA_WIDTH (16),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .wb_clk_i(clk),      .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc),   .m0_stb_i(m0_stb),   .m0_we_i(m0_we),
        .m0_adr_i(m0_adr),   .m0_dat_i(m0_dat),   .m0_sel_i(m0_sel),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack),   .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc),   .m1_stb_i(m1_stb),   .m1_we_i(m1_we),
        .m1_adr_i(m1_adr),   .m1_dat_i(m1_dat),   .m1_sel_i(m1_sel),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack),   .m1_err_o(m1_err),
        .s_cyc_o(s_cyc),     .s_stb_o(s_stb),     .s_we_o(s_we),
        .s_adr_o(s_adr),     .s_dat_o(s_dat_o),   .s_sel_o(s_sel),
        .s_dat_i(s_dat),     .s_ack_i(s_ack),
        .grant_o(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [82:0] model_out();
        logic        sc, ss, sw;
        logic [23:0] sa;
        logic [15:0] sd;
        logic [1:0]  sl, ack, err, gr;
        {sc, ss, sw, sa, sd, sl, ack, err, gr} = '0;
        if (md == 1) begin
            sc = own ? m1_cyc : m0_cyc;
            ss = own ? m1_stb : m0_stb;
            sw = own ? m1_we  : m0_we;
            sa = own ? m1_adr : m0_adr;
            sd = own ? m1_dat : m0_dat;
            sl = own ? m1_sel : m0_sel;
            gr[own]  = 1'b1;
            ack[own] = s_ack;
            err[own] = !s_ack && sc && cnt == T;
        end
        return {sc, ss, sw, sa, sd, sl, ack, err, gr, s_dat, s_dat};
    endfunction

    task automatic model_step();
        bit r0, r1, oc;
        r0 = m0_cyc & m0_stb;
        r1 = m1_cyc & m1_stb;
        oc = own ? m1_cyc : m0_cyc;
        if (rst) begin
            md = 0; own = 0; lst = 1; cnt = 0;
        end else if (md == 0) begin
            if (r0 || r1) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                own = (r0 && r1) ? 1 - lst : (r0 ? 0 : 1);
`else
                own = r0 ? 0 : 1;
`endif
                cnt = 0;
                md  = 1;
            end
        end else if (md == 1) begin
            if (s_ack) begin
                md = 0; lst = own;
            end else if (!oc || cnt == T) begin
                md = 2; cnt = 0;
            end else begin
                cnt = (cnt + 1 > T) ? T : cnt + 1;
            end
        end else begin
            if (s_ack || cnt == T) md = 0;
            else cnt = (cnt + 1 > T) ? T : cnt + 1;
        end
    endtask

    // one clock: compare against the model mid-cycle, then advance the model on the edge
    task automatic tick();
        @(negedge clk);
        chk("model", {s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel, m1_ack, m0_ack,
                      m1_err, m0_err, grant, m0_dat_o, m1_dat_o}, model_out());
        cap_cyc = s_cyc; cap_stb = s_stb; cap_we = s_we; cap_grant = grant;
        cap_ack0 = m0_ack; cap_ack1 = m1_ack; cap_err0 = m0_err; cap_err1 = m1_err;
        cap_sdat = s_dat_o; cap_sel = s_sel; cap_mdat0 = m0_dat_o; cap_mdat1 = m1_dat_o;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic req(input int n, input bit v);
        if (n == 0) begin m0_cyc = v; m0_stb = v; end
        else        begin m1_cyc = v; m1_stb = v; end
    endtask

    typedef struct {
        logic        rst, r0, we0, r1, we1, ack;
        logic [15:0] sdat;
        logic        e_cyc, e_stb, e_we;
        logic [1:0]  e_grant, e_ack, e_err;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int errpos, busyc, lowc;
        bit sawack;
        logic [1:0] order[4];
        logic [1:0] exp_g;

        tbl[0]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{0, 0, 0, 1, 0, 0, 16'h0000, 1, 1, 0, 2'b10, 2'b00, 2'b00};
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = tbl[2];
        tbl[6]  = tbl[2];
        tbl[7]  = '{0, 0, 0, 1, 0, 1, 16'hBEEF, 1, 1, 0, 2'b10, 2'b10, 2'b00};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{0, 1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{0, 1, 1, 0, 0, 0, 16'h0000, 1, 1, 1, 2'b01, 2'b00, 2'b00};
        tbl[11] = '{0, 1, 1, 0, 0, 1, 16'h5A5A, 1, 1, 1, 2'b01, 2'b01, 2'b00};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[13] = '{0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 2'b01, 2'b00, 2'b00};
        tbl[14] = '{0, 0, 0, 0, 0, 1, 16'h7777, 0, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 2'b00, 2'b00};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        md = 0; own = 0; lst = 1; cnt = 0;
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; req(0, tbl[i].r0); m0_we = tbl[i].we0;
            req(1, tbl[i].r1); m1_we = tbl[i].we1;
            s_ack = tbl[i].ack; s_dat = tbl[i].sdat;
            tick();
            chk($sformatf("row%0d", i),
                {cap_cyc, cap_stb, cap_we, cap_grant, cap_ack1, cap_ack0, cap_err1, cap_err0},
                {tbl[i].e_cyc, tbl[i].e_stb, tbl[i].e_we, tbl[i].e_grant, tbl[i].e_ack,
                 tbl[i].e_err});
            chk($sformatf("row%0d_rdata", i), {cap_mdat0, cap_mdat1}, {tbl[i].sdat, tbl[i].sdat});
            if (tbl[i].e_we) chk("wr_dat_sel", {cap_sdat, cap_sel}, {16'h1234, 2'b01});
        end
        s_ack = 0; m0_we = 0;

        // timeout: error on the 9th serving cycle, then 9 drain + 1 idle cycles with stb low
        req(0, 1);
        tick();
        errpos = -1; busyc = 0; sawack = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            sawack |= cap_ack0;
            if (cap_stb) busyc++;
            if (cap_err0) begin
                errpos = busyc;
                break;
            end
        end
        chk("timeout_err_cycle", errpos, 9);
        lowc = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            sawack |= cap_ack0;
            if (cap_err0) chk("err_single_pulse", cap_err0, 1'b0);
            if (!cap_stb) lowc++;
            else break;
        end
        chk("timeout_drain_len", lowc, 10);
        chk("timeout_no_ack", sawack, 1'b0);
        s_ack = 1; tick(); s_ack = 0; req(0, 0); tick();

        // master 1 abandons mid-transfer, late ack is swallowed, pending master 0 then served
        req(1, 1);
        tick();
        tick();
        chk("abandon_grant", cap_grant, 2'b10);
        tick();
        req(1, 0); req(0, 1);
        tick();
        tick(); tick();
        s_ack = 1; tick(); s_ack = 0;
        chk("late_ack_swallowed", {cap_ack1, cap_ack0, cap_cyc}, 3'b000);
        tick();
        chk("idle_after_drain", {cap_stb, cap_grant}, 3'b000);
        tick();
        chk("m0_after_drain", {cap_stb, cap_grant}, 3'b101);
        s_ack = 1; tick(); s_ack = 0; req(0, 0); tick();

        // reset in the middle of a transfer
        req(0, 1);
        tick(); tick();
        rst = 1; tick(); rst = 0; req(0, 0);
        tick();
        chk("post_reset", {cap_cyc, cap_grant, cap_ack0, cap_ack1, cap_err0, cap_err1}, 7'b0);
        req(0, 1);
        tick();
        s_ack = 1; s_dat = 16'hCAFE; tick(); s_ack = 0;
        chk("post_reset_serve", {cap_ack0, cap_grant, cap_mdat0}, {1'b1, 2'b01, 16'hCAFE});
        req(0, 0); tick();

        // contention order
        rst = 1; tick(); rst = 0;
        req(0, 1); req(1, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            s_ack = 1; tick(); s_ack = 0;
            order[k] = cap_grant;
        end
        req(0, 0); req(1, 0); tick();
        for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            chk($sformatf("grant_order%0d", k), order[k], exp_g);
        end

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst    = ($urandom_range(63) == 0);
            m0_cyc = ($urandom_range(3) != 0);
            m0_stb = m0_cyc & ($urandom_range(4) != 0);
            m0_we  = 1'($urandom);
            m0_adr = 24'($urandom);
            m0_dat = 16'($urandom);
            m0_sel = 2'($urandom);
            m1_cyc = ($urandom_range(3) != 0);
            m1_stb = m1_cyc & ($urandom_range(4) != 0);
            m1_we  = 1'($urandom);
            m1_adr = 24'($urandom);
            m1_dat = 16'($urandom);
            m1_sel = 2'($urandom);
            s_ack  = ($urandom_range(5) == 0);
            s_dat  = 16'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
